// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request sequencer for the 8-bit ALU with chaining and a 2-entry response FIFO
// Two-entry shift-register FIFO: entry 0 is always the head, and freed slots are cleared to zero.
module rsp_fifo #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);
    logic [DW-1:0] entry0;
    logic [DW-1:0] entry1;
    logic          pop_ok;

    assign pop_ok = pop && (count != 2'd0);
    assign head   = entry0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_chain,
    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overF,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_overF,
    output logic             busy
);
    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [WIDTH-1:0] last_result;
    logic [1:0]       fifo_count;
    logic [WIDTH+2:0] fifo_head;
    logic             accept;
    logic             capture;

    // req_ready is gated by reset so it reads 0 while reset is held low.
    assign req_ready = reset && (state == S_IDLE) && (fifo_count != 2'd2);
    assign accept    = req_valid && req_ready;
    // Counter expires after ALU_LAT edges; capture happens on the edge after that.
    assign capture   = (state == S_WAIT) && (wait_cnt == '0);
    assign busy      = (state == S_WAIT);
    assign rsp_valid = (fifo_count != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            alu_inA     <= '0;
            alu_inB     <= '0;
            alu_sel     <= '0;
            last_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_inA  <= req_chain ? last_result : req_a;
                        alu_inB  <= req_b;
                        alu_sel  <= req_sel;
                        wait_cnt <= CNT_W'(ALU_LAT);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        last_result <= alu_result;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rsp_fifo #(.DW(WIDTH + 3)) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data ({alu_result, alu_zero, alu_carry, alu_overF}),
        .pop       (rsp_ready),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign {rsp_result, rsp_zero, rsp_carry, rsp_overF} = fifo_head;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed bench for alu_op_sequencer against a queue-based model
module tb_alu_op_sequencer;
    localparam int WIDTH   = 8;
    localparam int SEL_W   = 3;
    localparam int ALU_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [SEL_W-1:0] req_sel = '0;
    logic             req_chain = 1'b0;
    logic [WIDTH-1:0] alu_inA;
    logic [WIDTH-1:0] alu_inB;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_zero = 1'b0;
    logic             alu_carry = 1'b0;
    logic             alu_overF = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_overF;
    logic             busy;

    alu_op_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .req_chain  (req_chain),
        .alu_inA    (alu_inA),
        .alu_inB    (alu_inB),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_overF  (alu_overF),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .rsp_overF  (rsp_overF),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ALU stub: add with flags for sel=1, XOR otherwise; one registered stage.
    function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        if (sel == 3'b001) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end else begin
            r = a ^ b;
            c = 1'b0;
            v = 1'b0;
        end
        return {r, (r == 8'h00), c, v};
    endfunction

    always @(posedge clk)
        {alu_result, alu_zero, alu_carry, alu_overF} <= alu_fn(alu_inA, alu_inB, alu_sel);

    logic [10:0] exp_q[$];
    bit          pend;
    int          pend_cnt;
    logic [10:0] pend_val;
    logic [7:0]  m_last;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [2:0]  m_sel;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    bit          last_acc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        pend   = 1'b0;
        m_last = '0;
        m_a    = '0;
        m_b    = '0;
        m_sel  = '0;
    endtask

    task automatic check_state();
        logic [10:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 11'h000;
        check("req_ready", req_ready, rst_n && !pend && (exp_q.size() < 2));
        check("busy", busy, pend);
        check("rsp_valid", rsp_valid, exp_q.size() != 0);
        check("rsp_head", {rsp_result, rsp_zero, rsp_carry, rsp_overF}, head);
        check("alu_inA", alu_inA, m_a);
        check("alu_inB", alu_inB, m_b);
        check("alu_sel", alu_sel, m_sel);
    endtask

    task automatic step();
        bit         acc;
        bit         pop;
        logic [7:0] a;
        acc = req_valid && rst_n && !pend && (exp_q.size() < 2);
        pop = rsp_ready && rst_n && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        cyc++;
        last_acc = 1'b0;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    exp_q.push_back(pend_val);
                    m_last = pend_val[10:3];
                    pend   = 1'b0;
                end
            end
            if (acc) begin
                a        = req_chain ? m_last : req_a;
                m_a      = a;
                m_b      = req_b;
                m_sel    = req_sel;
                pend_val = alu_fn(a, req_b, req_sel);
                pend     = 1'b1;
                pend_cnt = ALU_LAT + 1;
                last_acc = 1'b1;
                acc_cnt++;
            end
        end
        check_state();
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                         input logic ch, output int acc_cyc);
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        req_chain = ch;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        check("issue_accepted", last_acc, 1'b1);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_chain = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int n0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready_low", req_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check_state();
        step();
        step();

        // single op: 0x33 + 0xA7
        issue(8'h33, 8'hA7, 3'b001, 1'b0, t1);
        step();
        check("single_lat1", rsp_valid, 1'b0);
        step();
        check("single_valid", rsp_valid, 1'b1);
        check("single_res", rsp_result, 8'hDA);
        check("single_flags", {rsp_zero, rsp_carry, rsp_overF}, 3'b000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("single_pop", rsp_valid, 1'b0);

        // chaining
        issue(8'hFF, 8'h01, 3'b001, 1'b0, t1);
        step();
        step();
        check("chain_res1", rsp_result, 8'h00);
        check("chain_flags1", {rsp_zero, rsp_carry, rsp_overF}, 3'b110);
        rsp_ready = 1'b1;
        issue(8'h77, 8'h05, 3'b001, 1'b1, t1);
        rsp_ready = 1'b0;
        check("chain_a", alu_inA, 8'h00);
        step();
        step();
        check("chain_res2", rsp_result, 8'h05);
        check("chain_flags2", {rsp_zero, rsp_carry, rsp_overF}, 3'b000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // backpressure with the FIFO filling up
        issue(8'h10, 8'h20, 3'b001, 1'b0, t1);
        issue(8'h30, 8'h40, 3'b001, 1'b0, t2);
        check("bp_spacing", t2 - t1, ALU_LAT + 2);
        req_a     = 8'h50;
        req_b     = 8'h60;
        req_sel   = 3'b001;
        req_valid = 1'b1;
        n0 = acc_cnt;
        repeat (8) step();
        check("bp_held", acc_cnt - n0, 0);
        check("bp_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_no_acc_on_pop", acc_cnt - n0, 0);
        check("bp_ready_after_pop", req_ready, 1'b1);
        step();
        check("bp_third_acc", acc_cnt - n0, 1);
        req_valid = 1'b0;
        check("bp_order1", rsp_result, 8'h70);
        rsp_ready = 1'b1;
        step();
        step();
        check("bp_order2", rsp_result, 8'hB0);
        step();
        rsp_ready = 1'b0;
        check("bp_drained", rsp_valid, 1'b0);

        // simultaneous push and pop
        issue(8'h01, 8'h02, 3'b001, 1'b0, t1);
        step();
        step();
        issue(8'h11, 8'h22, 3'b001, 1'b0, t1);
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("sim_valid", rsp_valid, 1'b1);
        check("sim_head", rsp_result, 8'h33);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("sim_empty", rsp_valid, 1'b0);

        // reset mid-op
        issue(8'h44, 8'h55, 3'b001, 1'b0, t1);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("rst_no_rsp", rsp_valid, 1'b0);
        issue(8'h99, 8'h07, 3'b001, 1'b1, t1);
        check("rst_chain_a", alu_inA, 8'h00);
        step();
        step();
        check("rst_chain_res", rsp_result, 8'h07);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // randomized traffic
        repeat (600) begin
            req_valid = 1'($urandom_range(0, 1));
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            req_sel   = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
            req_chain = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
